// File: rtl/pcq_clks_ctrl_if.sv
// Request/response bundle of the thold/sg source controller.
// slave: the controller; master: whoever requests clock modes and watches status.
interface pcq_clks_ctrl_if;
   logic       run_req;
   logic       scan_req;
   logic       pm_sleep;
   logic       fce_req;
   logic       ccflush_out_dc;
   logic       func_sl_thold_5;
   logic       func_slp_sl_thold_5;
   logic       func_nsl_thold_5;
   logic       func_slp_nsl_thold_5;
   logic       ary_nsl_thold_5;
   logic       ary_slp_nsl_thold_5;
   logic       cfg_sl_thold_5;
   logic       cfg_slp_sl_thold_5;
   logic       abst_sl_thold_5;
   logic       abst_slp_sl_thold_5;
   logic       regf_sl_thold_5;
   logic       regf_slp_sl_thold_5;
   logic       gptr_sl_thold_5;
   logic       time_sl_thold_5;
   logic       repr_sl_thold_5;
   logic       rtim_sl_thold_5;
   logic       sg_5;
   logic       fce_5;
   logic       clks_running;
   logic       clks_stopped;
   logic [2:0] state_dbg;

   modport slave (
      input  run_req, scan_req, pm_sleep, fce_req,
      output ccflush_out_dc,
      output func_sl_thold_5, func_slp_sl_thold_5, func_nsl_thold_5, func_slp_nsl_thold_5,
      output ary_nsl_thold_5, ary_slp_nsl_thold_5, cfg_sl_thold_5, cfg_slp_sl_thold_5,
      output abst_sl_thold_5, abst_slp_sl_thold_5, regf_sl_thold_5, regf_slp_sl_thold_5,
      output gptr_sl_thold_5, time_sl_thold_5, repr_sl_thold_5, rtim_sl_thold_5,
      output sg_5, fce_5, clks_running, clks_stopped, state_dbg
   );

   modport master (
      output run_req, scan_req, pm_sleep, fce_req,
      input  ccflush_out_dc,
      input  func_sl_thold_5, func_slp_sl_thold_5, func_nsl_thold_5, func_slp_nsl_thold_5,
      input  ary_nsl_thold_5, ary_slp_nsl_thold_5, cfg_sl_thold_5, cfg_slp_sl_thold_5,
      input  abst_sl_thold_5, abst_slp_sl_thold_5, regf_sl_thold_5, regf_slp_sl_thold_5,
      input  gptr_sl_thold_5, time_sl_thold_5, repr_sl_thold_5, rtim_sl_thold_5,
      input  sg_5, fce_5, clks_running, clks_stopped, state_dbg
   );
endinterface

// File: rtl/pcq_clks_ctrl.sv
// Source of the level-5 thold/sg/fce tree: sequences flush, clock start/stop,
// power-save sleep and scan entry/exit, and reports settled run/stop status
// only after the staging latency has elapsed.
// Transition-driven outputs (tholds, sg, fce, flush, clks_running) are
// registered from the next state so they move on the edge that enters it;
// clks_stopped is a status flag raised one cycle after settling in STOPPED.
module pcq_clks_ctrl #(
   parameter int STG_DEPTH = 5,
   parameter int FLUSH_CYC = 6
) (
   input logic             nclk,
   input logic             rst,
   pcq_clks_ctrl_if.slave  bus
);
   localparam int CMAXV = (STG_DEPTH > FLUSH_CYC) ? STG_DEPTH : FLUSH_CYC;
   localparam int CW    = $clog2(CMAXV + 1);

   typedef enum logic [2:0] {
      S_FLUSH      = 3'd0,
      S_STOPPED    = 3'd1,
      S_START_WAIT = 3'd2,
      S_RUNNING    = 3'd3,
      S_STOP_WAIT  = 3'd4,
      S_SCAN_SETUP = 3'd5,
      S_SCANNING   = 3'd6,
      S_SCAN_EXIT  = 3'd7
   } state_t;

   state_t          r_state, w_ns;
   logic [CW-1:0]   r_cnt;
   logic            r_run, r_scan, r_sleep, r_fce;
   logic            w_stg_done, w_flush_done;

   // thold bit order: func_sl, func_slp_sl, func_nsl, func_slp_nsl, ary_nsl,
   // ary_slp_nsl, cfg_sl, cfg_slp_sl, abst_sl, abst_slp_sl, regf_sl,
   // regf_slp_sl, gptr_sl, time_sl, repr_sl, rtim_sl (msb..lsb)
   logic [15:0]     r_th, w_th;
   logic            r_sg, r_fce5, r_flush, r_running, r_stopped;
   logic            w_sg, w_fce5, w_flush, w_running, w_stopped;
   logic            w_run_dom, w_awake, w_scn;

   assign w_stg_done   = (r_cnt == CW'(STG_DEPTH - 1));
   assign w_flush_done = (r_cnt == CW'(FLUSH_CYC - 1));

   // Input sampling: every decision uses these registered copies.
   always_ff @(posedge nclk or posedge rst) begin
      if (rst) begin
         r_run   <= 1'b0;
         r_scan  <= 1'b0;
         r_sleep <= 1'b0;
         r_fce   <= 1'b0;
      end else begin
         r_run   <= bus.run_req;
         r_scan  <= bus.scan_req;
         r_sleep <= bus.pm_sleep;
         r_fce   <= bus.fce_req;
      end
   end

   // State register and dwell counter (cleared on each state entry, saturating).
   always_ff @(posedge nclk or posedge rst) begin
      if (rst) begin
         r_state <= S_FLUSH;
         r_cnt   <= '0;
      end else begin
         r_state <= w_ns;
         if (w_ns != r_state)           r_cnt <= '0;
         else if (r_cnt != CW'(CMAXV))  r_cnt <= r_cnt + 1'b1;
      end
   end

   // Next-state decision; scan beats run, and RUNNING always drains via STOPPED.
   always_comb begin
      w_ns = r_state;
      case (r_state)
         S_FLUSH:      if (w_flush_done) w_ns = S_STOPPED;
         S_STOPPED:    if (r_scan) w_ns = S_SCAN_SETUP;
                       else if (r_run) w_ns = S_START_WAIT;
         S_START_WAIT: if (w_stg_done) w_ns = S_RUNNING;
         S_RUNNING:    if (!r_run || r_scan) w_ns = S_STOP_WAIT;
         S_STOP_WAIT:  if (w_stg_done) w_ns = S_STOPPED;
         S_SCAN_SETUP: if (w_stg_done) w_ns = S_SCANNING;
         S_SCANNING:   if (!r_scan) w_ns = S_SCAN_EXIT;
         S_SCAN_EXIT:  if (w_stg_done) w_ns = S_STOPPED;
         default:      w_ns = S_FLUSH;
      endcase
   end

   // Output values for the state being entered; sleep only gates non-slp domains.
   always_comb begin
      w_run_dom = (w_ns == S_START_WAIT) || (w_ns == S_RUNNING);
      w_awake   = w_run_dom && !r_sleep;
      w_scn     = (w_ns == S_SCANNING);
      w_th      = '1;
      w_th[15]  = !(w_awake || w_scn);     // func_sl
      w_th[14]  = !(w_run_dom || w_scn);   // func_slp_sl
      w_th[13]  = !w_awake;                // func_nsl
      w_th[12]  = !w_run_dom;              // func_slp_nsl
      w_th[11]  = !w_awake;                // ary_nsl
      w_th[10]  = !w_run_dom;              // ary_slp_nsl
      w_th[9]   = !(w_awake || w_scn);     // cfg_sl
      w_th[8]   = !(w_run_dom || w_scn);   // cfg_slp_sl
      w_th[7]   = !(w_awake || w_scn);     // abst_sl
      w_th[6]   = !(w_run_dom || w_scn);   // abst_slp_sl
      w_th[5]   = !(w_awake || w_scn);     // regf_sl
      w_th[4]   = !(w_run_dom || w_scn);   // regf_slp_sl
      w_th[3]   = !w_scn;                  // gptr_sl
      w_th[2]   = !w_scn;                  // time_sl
      w_th[1]   = !w_scn;                  // repr_sl
      w_th[0]   = !(w_run_dom || w_scn);   // rtim_sl
      w_sg      = (w_ns == S_SCAN_SETUP) || w_scn || (w_ns == S_SCAN_EXIT);
      w_fce5    = w_scn && r_fce;
      w_flush   = (w_ns == S_FLUSH);
      w_running = (w_ns == S_RUNNING);
      w_stopped = (r_state == S_STOPPED) && (w_ns == S_STOPPED);
   end

   // Output registers.
   always_ff @(posedge nclk or posedge rst) begin
      if (rst) begin
         r_th      <= '1;
         r_sg      <= 1'b0;
         r_fce5    <= 1'b0;
         r_flush   <= 1'b1;
         r_running <= 1'b0;
         r_stopped <= 1'b0;
      end else begin
         r_th      <= w_th;
         r_sg      <= w_sg;
         r_fce5    <= w_fce5;
         r_flush   <= w_flush;
         r_running <= w_running;
         r_stopped <= w_stopped;
      end
   end

   assign bus.func_sl_thold_5      = r_th[15];
   assign bus.func_slp_sl_thold_5  = r_th[14];
   assign bus.func_nsl_thold_5     = r_th[13];
   assign bus.func_slp_nsl_thold_5 = r_th[12];
   assign bus.ary_nsl_thold_5      = r_th[11];
   assign bus.ary_slp_nsl_thold_5  = r_th[10];
   assign bus.cfg_sl_thold_5       = r_th[9];
   assign bus.cfg_slp_sl_thold_5   = r_th[8];
   assign bus.abst_sl_thold_5      = r_th[7];
   assign bus.abst_slp_sl_thold_5  = r_th[6];
   assign bus.regf_sl_thold_5      = r_th[5];
   assign bus.regf_slp_sl_thold_5  = r_th[4];
   assign bus.gptr_sl_thold_5      = r_th[3];
   assign bus.time_sl_thold_5      = r_th[2];
   assign bus.repr_sl_thold_5      = r_th[1];
   assign bus.rtim_sl_thold_5      = r_th[0];
   assign bus.sg_5                 = r_sg;
   assign bus.fce_5                = r_fce5;
   assign bus.ccflush_out_dc       = r_flush;
   assign bus.clks_running         = r_running;
   assign bus.clks_stopped         = r_stopped;
   assign bus.state_dbg            = r_state;
endmodule

// File: tb/tb_pcq_clks_ctrl.sv
// Directed bench for pcq_clks_ctrl: a table of {inputs, cycles to advance,
// expected outputs} walked in order, a hand-written scan-from-RUNNING
// sequence, and per-cycle ordering invariants.
module tb_pcq_clks_ctrl;
   logic nclk = 1'b0;
   logic rst  = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   pcq_clks_ctrl_if b ();

   pcq_clks_ctrl #(.STG_DEPTH(5), .FLUSH_CYC(6)) dut (
      .nclk (nclk),
      .rst  (rst),
      .bus  (b)
   );

   always #5 nclk = ~nclk;

   logic [15:0] th;
   assign th = {b.func_sl_thold_5, b.func_slp_sl_thold_5, b.func_nsl_thold_5,
                b.func_slp_nsl_thold_5, b.ary_nsl_thold_5, b.ary_slp_nsl_thold_5,
                b.cfg_sl_thold_5, b.cfg_slp_sl_thold_5, b.abst_sl_thold_5,
                b.abst_slp_sl_thold_5, b.regf_sl_thold_5, b.regf_slp_sl_thold_5,
                b.gptr_sl_thold_5, b.time_sl_thold_5, b.repr_sl_thold_5,
                b.rtim_sl_thold_5};

   localparam logic [15:0] ALL1 = 16'hFFFF;  // stopped / setup / exit
   localparam logic [15:0] RUNP = 16'h000E;  // running: gptr/time/repr held
   localparam logic [15:0] SLPP = 16'hAAAE;  // running + sleep
   localparam logic [15:0] SCNP = 16'h3C00;  // scanning: nsl high, sl low

   typedef struct {
      bit        rst, run, scan, sleep, fce;
      int        n;       // posedges to advance; 0 = check 1ns after driving
      bit [2:0]  st;
      bit [15:0] th;
      bit        sg, fce5, ccf, running, stopped;
   } vec_t;

   vec_t tbl[35];

   function automatic vec_t mk(bit r, bit run, bit scan, bit slp, bit fce, int n,
                               bit [2:0] st, bit [15:0] t, bit sg, bit f5,
                               bit ccf, bit rn, bit sp);
      vec_t v;
      v.rst = r; v.run = run; v.scan = scan; v.sleep = slp; v.fce = fce; v.n = n;
      v.st = st; v.th = t; v.sg = sg; v.fce5 = f5; v.ccf = ccf;
      v.running = rn; v.stopped = sp;
      return v;
   endfunction

   function automatic logic [23:0] obs_pack();
      return {b.state_dbg, th, b.sg_5, b.fce_5, b.ccflush_out_dc,
              b.clks_running, b.clks_stopped};
   endfunction

   task automatic chk(input string nm, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Ordering invariants checked every cycle once the table starts.
   bit          mon_en = 1'b0;
   bit          prev_ok = 1'b0;
   logic [15:0] prev_th;
   logic        prev_sg;
   always @(negedge nclk) begin
      if (mon_en && !rst) begin
         n_vec++;
         if (b.clks_running && b.clks_stopped) begin
            n_err++;
            $display("FAIL run_stop_excl: running=%b stopped=%b, required not both 1",
                     b.clks_running, b.clks_stopped);
         end
         if (prev_ok && (b.sg_5 != prev_sg) && ((prev_th & ~th) != 16'h0)) begin
            n_err++;
            $display("FAIL sg_vs_thold_fall: sg %b->%b while tholds %h->%h, required no fall",
                     prev_sg, b.sg_5, prev_th, th);
         end
         prev_th <= th;
         prev_sg <= b.sg_5;
         prev_ok <= 1'b1;
      end else begin
         prev_ok <= 1'b0;
      end
   end

   initial begin
      //              rst run scn slp fce  n  st  tholds  sg f5 ccf rn sp
      tbl[0]  = mk(1, 0, 0, 0, 0, 0, 3'd0, ALL1, 0, 0, 1, 0, 0); // reset values
      tbl[1]  = mk(0, 0, 0, 0, 0, 5, 3'd0, ALL1, 0, 0, 1, 0, 0); // still flushing
      tbl[2]  = mk(0, 0, 0, 0, 0, 1, 3'd1, ALL1, 0, 0, 0, 0, 0); // flush ends
      tbl[3]  = mk(0, 0, 0, 0, 0, 1, 3'd1, ALL1, 0, 0, 0, 0, 1); // stopped reported
      tbl[4]  = mk(0, 1, 0, 0, 0, 1, 3'd1, ALL1, 0, 0, 0, 0, 1); // input latency
      tbl[5]  = mk(0, 1, 0, 0, 0, 1, 3'd2, RUNP, 0, 0, 0, 0, 0); // tholds drop
      tbl[6]  = mk(0, 1, 0, 0, 0, 4, 3'd2, RUNP, 0, 0, 0, 0, 0);
      tbl[7]  = mk(0, 1, 0, 0, 0, 1, 3'd3, RUNP, 0, 0, 0, 1, 0); // running
      tbl[8]  = mk(0, 1, 0, 1, 0, 1, 3'd3, RUNP, 0, 0, 0, 1, 0);
      tbl[9]  = mk(0, 1, 0, 1, 0, 1, 3'd3, SLPP, 0, 0, 0, 1, 0); // sleep
      tbl[10] = mk(0, 1, 0, 0, 0, 2, 3'd3, RUNP, 0, 0, 0, 1, 0); // wake
      tbl[11] = mk(0, 0, 0, 0, 0, 1, 3'd3, RUNP, 0, 0, 0, 1, 0);
      tbl[12] = mk(0, 0, 0, 0, 0, 1, 3'd4, ALL1, 0, 0, 0, 0, 0); // stop_wait
      tbl[13] = mk(0, 1, 0, 0, 0, 4, 3'd4, ALL1, 0, 0, 0, 0, 0); // run ignored
      tbl[14] = mk(0, 1, 0, 0, 0, 1, 3'd1, ALL1, 0, 0, 0, 0, 0);
      tbl[15] = mk(0, 1, 0, 0, 0, 1, 3'd2, RUNP, 0, 0, 0, 0, 0); // restart
      tbl[16] = mk(0, 0, 0, 0, 0, 5, 3'd3, RUNP, 0, 0, 0, 1, 0);
      tbl[17] = mk(0, 0, 0, 0, 0, 1, 3'd4, ALL1, 0, 0, 0, 0, 0);
      tbl[18] = mk(0, 0, 0, 0, 0, 5, 3'd1, ALL1, 0, 0, 0, 0, 0);
      tbl[19] = mk(0, 0, 0, 0, 0, 1, 3'd1, ALL1, 0, 0, 0, 0, 1);
      tbl[20] = mk(0, 1, 1, 0, 1, 1, 3'd1, ALL1, 0, 0, 0, 0, 1); // scan+run
      tbl[21] = mk(0, 1, 1, 0, 1, 1, 3'd5, ALL1, 1, 0, 0, 0, 0); // scan wins
      tbl[22] = mk(0, 1, 1, 0, 1, 4, 3'd5, ALL1, 1, 0, 0, 0, 0);
      tbl[23] = mk(0, 1, 1, 0, 1, 1, 3'd6, SCNP, 1, 1, 0, 0, 0); // scanning
      tbl[24] = mk(0, 1, 1, 0, 0, 2, 3'd6, SCNP, 1, 0, 0, 0, 0); // fce follows
      tbl[25] = mk(0, 1, 1, 0, 1, 2, 3'd6, SCNP, 1, 1, 0, 0, 0);
      tbl[26] = mk(0, 0, 0, 0, 1, 1, 3'd6, SCNP, 1, 1, 0, 0, 0);
      tbl[27] = mk(0, 0, 0, 0, 1, 1, 3'd7, ALL1, 1, 0, 0, 0, 0); // scan exit
      tbl[28] = mk(0, 0, 0, 0, 1, 4, 3'd7, ALL1, 1, 0, 0, 0, 0);
      tbl[29] = mk(0, 0, 0, 0, 1, 1, 3'd1, ALL1, 0, 0, 0, 0, 0); // sg falls
      tbl[30] = mk(0, 0, 0, 0, 1, 1, 3'd1, ALL1, 0, 0, 0, 0, 1);
      tbl[31] = mk(0, 0, 0, 1, 0, 2, 3'd1, ALL1, 0, 0, 0, 0, 1); // sleep inert
      tbl[32] = mk(0, 0, 1, 0, 1, 7, 3'd6, SCNP, 1, 1, 0, 0, 0);
      tbl[33] = mk(1, 0, 1, 0, 1, 0, 3'd0, ALL1, 0, 0, 1, 0, 0); // async reset
      tbl[34] = mk(0, 0, 0, 0, 0, 6, 3'd1, ALL1, 0, 0, 0, 0, 0); // reflush

      b.run_req = 0; b.scan_req = 0; b.pm_sleep = 0; b.fce_req = 0;
      rst = 1'b1;
      @(negedge nclk);
      mon_en = 1'b1;

      for (int i = 0; i < 35; i++) begin
         logic [23:0] exp_v, got_v;
         rst        = tbl[i].rst;
         b.run_req  = tbl[i].run;
         b.scan_req = tbl[i].scan;
         b.pm_sleep = tbl[i].sleep;
         b.fce_req  = tbl[i].fce;
         if (tbl[i].n == 0) #1;
         else begin
            repeat (tbl[i].n) @(posedge nclk);
            @(negedge nclk);
         end
         exp_v = {tbl[i].st, tbl[i].th, tbl[i].sg, tbl[i].fce5, tbl[i].ccf,
                  tbl[i].running, tbl[i].stopped};
         got_v = obs_pack();
         n_vec++;
         if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL vec%0d: got {st,th,sg,fce,ccf,run,stp}=%h expected %h",
                     i, got_v, exp_v);
         end
      end

      // Scan requested while RUNNING must drain through STOP_WAIT and STOPPED.
      // Enters here at a negedge shortly after rst release, in STOPPED.
      @(negedge nclk);
      b.run_req = 1;
      repeat (8) @(posedge nclk);
      @(negedge nclk);
      chk("seq_running", b.state_dbg, 3);
      chk("seq_running_flag", b.clks_running, 1);
      b.scan_req = 1;
      repeat (2) @(posedge nclk);
      @(negedge nclk);
      chk("seq_stop_wait", b.state_dbg, 4);
      chk("seq_stop_wait_sg", b.sg_5, 0);
      chk("seq_stop_wait_th", th, ALL1);
      repeat (5) @(posedge nclk);
      @(negedge nclk);
      chk("seq_stopped", b.state_dbg, 1);
      @(posedge nclk);
      @(negedge nclk);
      chk("seq_scan_setup", b.state_dbg, 5);
      chk("seq_scan_setup_sg", b.sg_5, 1);
      chk("seq_scan_setup_th", th, ALL1);

      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
